// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter.
// Accepts a word over a valid/ready handshake and shifts it out MSB-first,
// one bit per ce=1 edge. A one-word holding buffer lets the next frame start
// on the edge that retires the last bit, so frames run back-to-back with no
// gap. The receiving SIPO shifts left and inserts at the LSB.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] hold_nxt;
  logic             hold_valid;
  logic             hold_valid_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic             serial_out_nxt;
  logic             serial_valid_nxt;
  logic             frame_start_nxt;
  logic             busy_nxt;
  logic             accept;
  logic             last_bit;

  // The holding buffer is the only thing that can refuse a word; reset also
  // blocks acceptance so nothing is sampled while the block is being cleared.
  assign load_ready = !rst && !hold_valid;
  assign accept     = load_valid && load_ready;
  assign last_bit   = (bit_cnt == LAST_IDX);

  // Control state and registered outputs; reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_valid   <= 1'b0;
      bit_cnt      <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_valid   <= hold_valid_nxt;
      bit_cnt      <= bit_cnt_nxt;
      serial_out   <= serial_out_nxt;
      serial_valid <= serial_valid_nxt;
      frame_start  <= frame_start_nxt;
      busy         <= busy_nxt;
    end
  end

  // Data registers carry no reset; their contents are qualified by the control state.
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
    hold  <= hold_nxt;
  end

  // Next state: leave SHIFT only when the last bit retires with nothing queued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (ce && last_bit && !hold_valid && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values for the current state and inputs.
  always_comb begin
    shreg_nxt        = shreg;
    hold_nxt         = hold;
    hold_valid_nxt   = hold_valid;
    bit_cnt_nxt      = bit_cnt;
    serial_out_nxt   = serial_out;
    serial_valid_nxt = serial_valid;
    frame_start_nxt  = frame_start;

    case (state)
      IDLE: begin
        if (accept) begin
          shreg_nxt        = load_data;
          serial_out_nxt   = load_data[WIDTH-1];
          serial_valid_nxt = 1'b1;
          frame_start_nxt  = 1'b1;
          bit_cnt_nxt      = '0;
        end else begin
          serial_out_nxt   = 1'b0;
          serial_valid_nxt = 1'b0;
          frame_start_nxt  = 1'b0;
        end
      end

      SHIFT: begin
        if (ce && last_bit) begin
          // Last bit retires: start the next frame immediately if one is ready.
          // hold_valid blocks load_ready, so the two branches below never overlap.
          if (hold_valid) begin
            shreg_nxt       = hold;
            hold_valid_nxt  = 1'b0;
            serial_out_nxt  = hold[WIDTH-1];
            frame_start_nxt = 1'b1;
            bit_cnt_nxt     = '0;
          end else if (accept) begin
            shreg_nxt       = load_data;
            serial_out_nxt  = load_data[WIDTH-1];
            frame_start_nxt = 1'b1;
            bit_cnt_nxt     = '0;
          end else begin
            serial_out_nxt   = 1'b0;
            serial_valid_nxt = 1'b0;
            frame_start_nxt  = 1'b0;
            bit_cnt_nxt      = '0;
          end
        end else begin
          if (ce) begin
            shreg_nxt       = {shreg[WIDTH-2:0], 1'b0};
            serial_out_nxt  = shreg[WIDTH-2];
            frame_start_nxt = 1'b0;
            bit_cnt_nxt     = bit_cnt + CNT_ONE;
          end
          if (accept) begin
            hold_nxt       = load_data;
            hold_valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        serial_out_nxt   = 1'b0;
        serial_valid_nxt = 1'b0;
        frame_start_nxt  = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt == SHIFT) || hold_valid_nxt;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer with a behavioural SIPO receiver
// on serial_out for loop-back checks.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         ce;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         load_ready;
  logic         serial_out;
  logic         serial_valid;
  logic         frame_start;
  logic         busy;

  logic [W-1:0] sipo;

  int n_checks;
  int n_errors;

  piso_serializer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiving SIPO: shifts left, inserts at the LSB on each valid ce=1 edge.
  always @(posedge clk) begin
    if (ce && serial_valid) sipo <= {sipo[W-2:0], serial_out};
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " serial_valid"}, serial_valid, 1'b0);
    check({tag, " serial_out"},   serial_out,   1'b0);
    check({tag, " busy"},         busy,         1'b0);
  endtask

  // Send one word with ce=1 tied and check every bit plus the SIPO result.
  task automatic send_frame(input logic [W-1:0] word);
    load_data  = word;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      check($sformatf("bit%0d of %h", i, word), serial_out, word[W-1-i]);
      check("frame valid", serial_valid, 1'b1);
      check("frame_start", frame_start, (i == 0));
      check("frame busy", busy, 1'b1);
      tick();
    end
    check_idle("after frame");
    check("sipo word", sipo, word);
  endtask

  initial begin
    logic [15:0] pair;
    logic [W-1:0] w;
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    ce         = 1'b1;
    load_data  = '0;
    load_valid = 1'b0;
    sipo       = '0;

    // Reset state
    tick();
    tick();
    check_idle("reset");
    check("reset frame_start", frame_start, 1'b0);
    check("reset load_ready", load_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("ready after reset", load_ready, 1'b1);

    // Single word A5
    send_frame(8'hA5);
    tick();
    check_idle("idle gap");

    // Back-to-back A5 then 3C through the holding buffer
    pair       = 16'hA53C;
    load_data  = 8'hA5;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("b2b bit c%0d", c), serial_out, pair[16-c]);
      check("b2b valid", serial_valid, 1'b1);
      check("b2b frame_start", frame_start, (c == 1 || c == 9));
      check("b2b busy", busy, 1'b1);
      if (c == 3) check("b2b ready full", load_ready, 1'b0);
      if (c == 9) check("b2b ready back", load_ready, 1'b1);
      load_data  = 8'h3C;
      load_valid = (c == 2);
      tick();
      load_valid = 1'b0;
    end
    check_idle("after b2b");
    check("sipo b2b", sipo, 8'h3C);

    // Bypass: accept FF on the last bit of frame 00, hold stays empty
    load_data  = 8'h00;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("bypass bit c%0d", c), serial_out, (c > 8));
      check("bypass valid", serial_valid, 1'b1);
      check("bypass frame_start", frame_start, (c == 1 || c == 9));
      check("bypass ready", load_ready, 1'b1);
      load_data  = 8'hFF;
      load_valid = (c == 8);
      tick();
      load_valid = 1'b0;
    end
    check_idle("after bypass");

    // ce pacing: one ce pulse every 4 cycles, load on a ce=0 edge
    w          = 8'hC3;
    ce         = 1'b0;
    load_data  = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      for (int j = 0; j < 4; j++) begin
        check($sformatf("pace bit%0d c%0d", k, j), serial_out, w[W-1-k]);
        check("pace valid", serial_valid, 1'b1);
        check("pace frame_start", frame_start, (k == 0));
        ce = (j == 3);
        tick();
      end
    end
    ce = 1'b0;
    check_idle("after pace");
    check("sipo pace", sipo, 8'hC3);
    ce = 1'b1;

    // Reset mid-frame with a buffered word
    load_data  = 8'hA5;
    load_valid = 1'b1;
    tick();
    load_data  = 8'h77;
    tick();
    load_valid = 1'b0;
    check("rst buffered ready", load_ready, 1'b0);
    tick();
    tick();
    check("rst bit3 value", serial_out, 1'b0);
    check("rst bit3 valid", serial_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("ready in reset", load_ready, 1'b0);
    tick();
    check_idle("mid reset");
    check("mid reset frame_start", frame_start, 1'b0);
    check("mid reset ready", load_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("ready after mid reset", load_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no stale frame", serial_valid, 1'b0);
    end
    send_frame(8'h5A);

    // Loop-back into the SIPO
    send_frame(8'h96);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
